// File: rtl/fir_stim_pkg.sv
// Shared types and constants for the FIR stimulus generator.
package fir_stim_pkg;

    typedef enum logic [1:0] {
        IMPULSE = 2'd0,
        STEP    = 2'd1,
        ALT     = 2'd2,
        LFSR    = 2'd3
    } stim_mode_t;

    typedef logic [1:0] stim_state_t;

    localparam stim_state_t IDLE = 2'd0;
    localparam stim_state_t RUN  = 2'd1;
    localparam stim_state_t DONE = 2'd2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/fir_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and advance; resets to RESET_SEED.
module fir_lfsr16
    import fir_stim_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/fir_stim_gen.sv
// Burst stimulus source for FIR filter inputs (impulse/step/alternate/LFSR).
// Optional FIR_STIM_GEN_ABORT_EN adds an abort input that ends a burst early.
module fir_stim_gen
    import fir_stim_pkg::*;
#(
    parameter int          OUTPUT_WIDTH = 16,
    parameter int          BURST_LEN    = 64,
    parameter int          RATE_DIV     = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [OUTPUT_WIDTH-1:0] amplitude,
`ifdef FIR_STIM_GEN_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    valid_out,
    output logic [OUTPUT_WIDTH-1:0] dout
);

    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int RATE_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(BURST_LEN);
    localparam logic [RATE_W-1:0] RATE_END = RATE_W'(RATE_DIV - 1);
    localparam logic [OUTPUT_WIDTH-1:0] AMP_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic [OUTPUT_WIDTH-1:0] AMP_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};

    stim_state_t             state_q;
    stim_mode_t              mode_q;
    logic [OUTPUT_WIDTH-1:0] amp_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [RATE_W-1:0]       rate_q;

    logic                    abort_req;
    logic                    accept;
    logic                    finish;
    logic                    emit;
    logic [15:0]             lfsr_state;
    logic [15:0]             lfsr_pick;
    logic [OUTPUT_WIDTH-1:0] lfsr_sample;
    stim_mode_t              cur_mode;
    logic [OUTPUT_WIDTH-1:0] cur_amp;
    logic [OUTPUT_WIDTH-1:0] neg_amp;
    logic                    odd_k;
    logic [OUTPUT_WIDTH-1:0] sample;

`ifdef FIR_STIM_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept = (state_q == IDLE) && start;
    assign finish = (state_q == RUN) && ((cnt_q == CNT_END) || abort_req);
    assign emit   = (state_q == RUN) && !finish && (rate_q == RATE_END);

    fir_lfsr16 #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .seed    (LFSR_SEED),
        .advance (emit),
        .state   (lfsr_state)
    );

    // The LFSR register holds the last emitted value; sample 0 is the seed itself.
    assign lfsr_pick = accept ? LFSR_SEED : lfsr_next(lfsr_state);

    generate
        if (OUTPUT_WIDTH <= 16) begin : g_trunc
            assign lfsr_sample = lfsr_pick[OUTPUT_WIDTH-1:0];
        end else begin : g_sext
            assign lfsr_sample = {{(OUTPUT_WIDTH-16){lfsr_pick[15]}}, lfsr_pick};
        end
    endgenerate

    assign cur_mode = accept ? stim_mode_t'(mode) : mode_q;
    assign cur_amp  = accept ? amplitude : amp_q;
    assign neg_amp  = (cur_amp == AMP_MIN) ? AMP_MAX : -cur_amp;
    assign odd_k    = accept ? 1'b0 : cnt_q[0];

    always_comb begin
        sample = '0;
        unique case (cur_mode)
            IMPULSE: sample = accept ? cur_amp : '0;
            STEP:    sample = cur_amp;
            ALT:     sample = odd_k ? neg_amp : cur_amp;
            LFSR:    sample = lfsr_sample;
            default: sample = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= IMPULSE;
            amp_q     <= '0;
            cnt_q     <= '0;
            rate_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid_out <= 1'b0;
            dout      <= '0;
        end else begin
            done      <= 1'b0;
            valid_out <= 1'b0;
            dout      <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        mode_q    <= stim_mode_t'(mode);
                        amp_q     <= amplitude;
                        // cnt_q counts samples already emitted, so sample 0 counts here
                        cnt_q     <= CNT_W'(1);
                        rate_q    <= '0;
                        busy      <= 1'b1;
                        valid_out <= 1'b1;
                        dout      <= sample;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else if (rate_q == RATE_END) begin
                        rate_q    <= '0;
                        cnt_q     <= cnt_q + 1'b1;
                        valid_out <= 1'b1;
                        dout      <= sample;
                    end else begin
                        rate_q <= rate_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Self-checking bench: two generator instances (different burst/rate) vs a behavioural model.
module tb_fir_stim_gen;

    localparam int BA = 4;
    localparam int RA = 1;
    localparam int BB = 5;
    localparam int RB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] amp;
`ifdef FIR_STIM_GEN_ABORT_EN
    logic        abort;
`endif

    logic        busy_a, done_a, valid_a;
    logic [15:0] dout_a;
    logic        busy_b, done_b, valid_b;
    logic [15:0] dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_stim_gen #(
        .OUTPUT_WIDTH (16),
        .BURST_LEN    (BA),
        .RATE_DIV     (RA),
        .LFSR_SEED    (16'hACE1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amplitude (amp),
`ifdef FIR_STIM_GEN_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy_a),
        .done      (done_a),
        .valid_out (valid_a),
        .dout      (dout_a)
    );

    fir_stim_gen #(
        .OUTPUT_WIDTH (16),
        .BURST_LEN    (BB),
        .RATE_DIV     (RB),
        .LFSR_SEED    (16'hACE1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amplitude (amp),
`ifdef FIR_STIM_GEN_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy_b),
        .done      (done_b),
        .valid_out (valid_b),
        .dout      (dout_b)
    );

    // Sample k of a burst, straight from the waveform definitions.
    function automatic logic [15:0] model_sample(int m, logic [15:0] a, int k);
        int v;
        logic [15:0] s;
        v = int'($signed(a));
        s = 16'hACE1;
        case (m)
            0: return (k == 0) ? a : 16'h0000;
            1: return a;
            2: begin
                if (k % 2 == 0) return a;
                v = -v;
                if (v > 32767) v = 32767;
                return 16'(v);
            end
            default: begin
                repeat (k) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
                return s;
            end
        endcase
    endfunction

    // Expected {busy, done, valid, dout} n cycles after the accepting edge.
    function automatic logic [18:0] exp_vec(int b, int r, int m, logic [15:0] a, int n,
                                            int abort_n);
        int done_n;
        done_n = 1 + (b - 1) * r + 1;
        if (abort_n >= 1 && abort_n < done_n) done_n = abort_n + 1;
        if (n < 1 || n > done_n) return 19'h0;
        if (n == done_n) return {1'b1, 1'b1, 1'b0, 16'h0000};
        if ((n - 1) % r == 0) return {1'b1, 1'b0, 1'b1, model_sample(m, a, (n - 1) / r)};
        return {1'b1, 1'b0, 1'b0, 16'h0000};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state got a=%b%b%b/%h b=%b%b%b/%h exp all zero",
                     busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b} !== 38'h0) begin
            errors++;
            $display("FAIL idle_after_reset got a=%b%b%b/%h b=%b%b%b/%h exp all zero",
                     busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b);
        end
    endtask

    task automatic test_modes();
        int          dm[4] = '{0, 2, 3, 1};
        logic [15:0] da[4] = '{16'd100, 16'h8000, 16'h1234, 16'hFFFB};
        logic [18:0] ea, eb;
        for (int t = 0; t < 16; t++) begin
            int          m;
            logic [15:0] a;
            if (t < 4) begin
                m = dm[t];
                a = da[t];
            end else begin
                m = $urandom_range(0, 3);
                a = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
            end
            @(negedge clk);
            start = 1'b1;
            mode  = 2'(m);
            amp   = a;
            for (int n = 1; n <= 18; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    start = 1'b0;
                    amp   = 16'($urandom);
                    mode  = 2'($urandom_range(0, 3));
                end
                ea = exp_vec(BA, RA, m, a, n, 0);
                eb = exp_vec(BB, RB, m, a, n, 0);
                checks++;
                if ({busy_a, done_a, valid_a, dout_a} !== ea) begin
                    errors++;
                    $display("FAIL modes_a t=%0d mode=%0d n=%0d got %h exp %h", t, m, n,
                             {busy_a, done_a, valid_a, dout_a}, ea);
                end
                checks++;
                if ({busy_b, done_b, valid_b, dout_b} !== eb) begin
                    errors++;
                    $display("FAIL modes_b t=%0d mode=%0d n=%0d got %h exp %h", t, m, n,
                             {busy_b, done_b, valid_b, dout_b}, eb);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] ea, eb;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd1;
        amp   = 16'd5;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            ea = exp_vec(BA, RA, 1, 16'd5, n, 0);
            checks++;
            if ({busy_a, done_a, valid_a, dout_a} !== ea) begin
                errors++;
                $display("FAIL pre_reset_a n=%0d got %h exp %h", n,
                         {busy_a, done_a, valid_a, dout_a}, ea);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b} !== 38'h0) begin
            errors++;
            $display("FAIL async_abort got a=%b%b%b/%h b=%b%b%b/%h exp all zero",
                     busy_a, done_a, valid_a, dout_a, busy_b, done_b, valid_b, dout_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
                errors++;
                $display("FAIL no_done_after_reset got %b exp 0000",
                         {busy_a, done_a, busy_b, done_b});
            end
        end
        start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            ea = exp_vec(BA, RA, 1, 16'd5, n, 0);
            eb = exp_vec(BB, RB, 1, 16'd5, n, 0);
            checks++;
            if ({busy_a, done_a, valid_a, dout_a} !== ea) begin
                errors++;
                $display("FAIL post_reset_a n=%0d got %h exp %h", n,
                         {busy_a, done_a, valid_a, dout_a}, ea);
            end
            checks++;
            if ({busy_b, done_b, valid_b, dout_b} !== eb) begin
                errors++;
                $display("FAIL post_reset_b n=%0d got %h exp %h", n,
                         {busy_b, done_b, valid_b, dout_b}, eb);
            end
        end
    endtask

    // start held high: ignored in RUN/DONE, re-accepted in the first IDLE cycle after DONE.
    task automatic test_back_to_back();
        int          pa, pb;
        logic [15:0] a;
        logic [18:0] ea, eb;
        pa = (1 + (BA - 1) * RA + 1) + 1;
        pb = (1 + (BB - 1) * RB + 1) + 1;
        a  = 16'($urandom);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd3;
        amp   = a;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            ea = exp_vec(BA, RA, 3, a, ((n - 1) % pa) + 1, 0);
            eb = exp_vec(BB, RB, 3, a, ((n - 1) % pb) + 1, 0);
            checks++;
            if ({busy_a, done_a, valid_a, dout_a} !== ea) begin
                errors++;
                $display("FAIL held_start_a n=%0d got %h exp %h", n,
                         {busy_a, done_a, valid_a, dout_a}, ea);
            end
            checks++;
            if ({busy_b, done_b, valid_b, dout_b} !== eb) begin
                errors++;
                $display("FAIL held_start_b n=%0d got %h exp %h", n,
                         {busy_b, done_b, valid_b, dout_b}, eb);
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ({busy_a, valid_a, busy_b, valid_b} !== 4'b0) begin
            errors++;
            $display("FAIL drain_idle got %b exp 0000", {busy_a, valid_a, busy_b, valid_b});
        end
    endtask

`ifdef FIR_STIM_GEN_ABORT_EN
    task automatic test_abort();
        logic [15:0] a;
        logic [18:0] ea, eb;
        a = 16'($urandom);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd1;
        amp   = a;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            ea = exp_vec(BA, RA, 1, a, n, 3);
            eb = exp_vec(BB, RB, 1, a, n, 3);
            checks++;
            if ({busy_a, done_a, valid_a, dout_a} !== ea) begin
                errors++;
                $display("FAIL abort_a n=%0d got %h exp %h", n,
                         {busy_a, done_a, valid_a, dout_a}, ea);
            end
            checks++;
            if ({busy_b, done_b, valid_b, dout_b} !== eb) begin
                errors++;
                $display("FAIL abort_b n=%0d got %h exp %h", n,
                         {busy_b, done_b, valid_b, dout_b}, eb);
            end
            abort = (n == 3);
        end
        abort = 1'b0;
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        amp   = 16'h0000;
`ifdef FIR_STIM_GEN_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_modes();
        test_reset_mid();
        test_back_to_back();
`ifdef FIR_STIM_GEN_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
